pipe_skid_buf: RTL and testbench
================================

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 1, payload width in bits.
REQ-002 SHALL have parameter INIT, default '0, reset value of both data registers.

Ports:
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock only.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-007 SHALL have port in_ready  output  1  buffer accepts this cycle; driven from state only.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_ready  input  1  downstream consumes this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  head entry, driven directly from a register.

Function
REQ-012 SHALL implement a 2-entry elastic stage: main register (head) plus skid register (second entry).
REQ-013 SHALL use states EMPTY (0 entries), ONE (head valid), FULL (head and skid valid).
REQ-014 SHALL define push = in_valid & in_ready & !flush and pop = out_valid & out_ready.
REQ-015 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY); neither SHALL depend combinationally on in_valid or out_ready.
REQ-016 SHALL make EMPTY transitions: push -> ONE, with in_data loaded into main.
REQ-017 SHALL make ONE transitions: push & !pop -> FULL (in_data into skid); push & pop -> ONE (in_data into main); pop & !push -> EMPTY; otherwise hold.
REQ-018 SHALL make FULL transitions: pop -> ONE (skid moves into main); no push is possible while FULL.
REQ-019 SHALL give 1-cycle latency: data pushed at edge N appears on out_data with out_valid high after edge N when the buffer was EMPTY.
REQ-020 SHALL sustain throughput of 1 entry/cycle when out_ready is held high.
REQ-021 SHALL preserve order strictly; no entry SHALL be dropped or duplicated.
REQ-022 SHALL, when flush is high at an edge, go to EMPTY regardless of push/pop; data registers MAY hold stale contents.
REQ-023 SHALL leave data registers unchanged when they are not loaded (enable-style update only).
REQ-024 SHALL treat out_data as don't-care while out_valid is low.

Reset
REQ-025 SHALL, while rst is high, force state = EMPTY, in_ready = 1, out_valid = 0, and main = skid = INIT, asynchronously.
REQ-026 SHALL discard all entries and return to EMPTY when rst is asserted mid-operation in any state.
REQ-027 SHALL perform no push or pop in the first edge after rst deasserts unless the handshake conditions hold at that edge.

Structure
REQ-028 SHALL take the state enum (EMPTY/ONE/FULL, 2-bit) from a shared package rvv_pipe_pkg, for reuse by other elastic stages.
REQ-029 SHALL implement data registers inline; no sub-module is natural for this block.
REQ-030 SHALL meet the scope target of roughly 120-200 lines of RTL.

Verification
REQ-031 SHALL cover single transfer (WIDTH=8): push 0xA5 into EMPTY with out_ready=0 -> next cycle out_valid=1, out_data=0xA5, in_ready=1.
REQ-032 SHALL cover skid fill: out_ready=0, push 0x11 then 0x22 -> state FULL, in_ready=0; then out_ready=1 -> pops 0x11, then 0x22, with in_ready=1 after the first pop.
REQ-033 SHALL cover streaming: in_valid=out_ready=1 for 16 cycles with data 0..15 -> outputs 0..15 in order, one per cycle, in_ready never low.
REQ-034 SHALL cover simultaneous events: state ONE holding 0x33, push 0x44 with pop at the same edge -> state ONE, out_data=0x44.
REQ-035 SHALL cover flush: FULL with 0x55/0x66, flush=1 with in_valid=1 -> next cycle EMPTY, out_valid=0, in_ready=1, and the input is not captured.
REQ-036 SHALL cover reset mid-operation: FULL, assert rst between edges -> out_valid=0 and in_ready=1 immediately, out_data=INIT; after release, a push of 0x77 -> out_data=0x77.

Source files
------------

// File: rtl/rvv_pipe_pkg.sv
// Shared definitions for elastic pipeline stages.
// The occupancy encoding is common to every stage that reuses this package.
package rvv_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage : rvv_pipe_pkg

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: a head register that drives out_data directly, plus a
// skid register that absorbs one extra beat, so both handshakes decode from state alone.
module pipe_skid_buf
    import rvv_pipe_pkg::*;
#(
    parameter int                WIDTH = 1,
    parameter logic [WIDTH-1:0]  INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    pipe_state_e      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    pipe_state_e      w_state_fsm;
    pipe_state_e      w_state_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;
    logic [WIDTH-1:0] w_main_nxt;

    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready;

    // Occupancy transitions and data-register load enables
    always_comb begin
        w_state_fsm      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_state_fsm = ONE;
                    w_load_main = 1'b1;
                end else begin
                    w_state_fsm = EMPTY;
                end
            end
            ONE: begin
                if (w_push && !w_pop) begin
                    w_state_fsm = FULL;
                    w_load_skid = 1'b1;
                end else if (w_push && w_pop) begin
                    w_state_fsm = ONE;
                    w_load_main = 1'b1;
                end else if (w_pop) begin
                    w_state_fsm = EMPTY;
                end else begin
                    w_state_fsm = ONE;
                end
            end
            FULL: begin
                // in_ready is low here, so only a pop can move the state
                if (w_pop) begin
                    w_state_fsm      = ONE;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end else begin
                    w_state_fsm = FULL;
                end
            end
            default: begin
                w_state_fsm = EMPTY;
            end
        endcase
    end

    assign w_state_nxt = flush ? EMPTY : w_state_fsm;
    assign w_main_nxt  = w_main_from_skid ? r_skid : in_data;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Head register, loaded only when a new head is selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= INIT;
        end else if (w_load_main) begin
            r_main <= w_main_nxt;
        end
    end

    // Skid register, loaded only when a beat arrives while the head is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid <= INIT;
        end else if (w_load_skid) begin
            r_skid <= in_data;
        end
    end

endmodule : pipe_skid_buf

// File: tb/tb_pipe_skid_buf.sv
// Scoreboard bench for pipe_skid_buf: stimulus queues expected beats and
// handshake states, a negedge monitor pops and compares them.
module tb_pipe_skid_buf;

    localparam logic [7:0] INIT_V = 8'hC3;

    typedef struct packed {
        logic       ir;
        logic       ov;
        logic       cd;
        logic [7:0] d;
        logic       ce;
    } stat_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    logic [7:0] exp_q[$];
    stat_t      stat_q[$];
    string      name_q[$];

    int vectors;
    int miscompares;

    pipe_skid_buf #(
        .WIDTH (8),
        .INIT  (INIT_V)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_stat(input string nm, input logic ir, input logic ov,
                               input logic cd, input logic [7:0] d, input logic ce);
        stat_t s;
        s.ir = ir;
        s.ov = ov;
        s.cd = cd;
        s.d  = d;
        s.ce = ce;
        stat_q.push_back(s);
        name_q.push_back(nm);
    endtask

    task automatic push_beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        exp_q.push_back(d);
    endtask

    // Monitor: check queued handshake expectations, then score any beat consumed at the next edge
    always @(negedge clk) begin
        stat_t      s;
        string      n;
        logic [7:0] e;
        while (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            n = name_q.pop_front();
            vectors = vectors + 1;
            if (in_ready !== s.ir) begin
                miscompares = miscompares + 1;
                $display("FAIL %s in_ready: got %b want %b", n, in_ready, s.ir);
            end
            vectors = vectors + 1;
            if (out_valid !== s.ov) begin
                miscompares = miscompares + 1;
                $display("FAIL %s out_valid: got %b want %b", n, out_valid, s.ov);
            end
            if (s.cd) begin
                vectors = vectors + 1;
                if (out_data !== s.d) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s out_data: got %h want %h", n, out_data, s.d);
                end
            end
            if (s.ce) begin
                vectors = vectors + 1;
                if (exp_q.size() != 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s pending beats: got %0d want 0", n, exp_q.size());
                end
            end
        end
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors = vectors + 1;
            if (exp_q.size() == 0) begin
                miscompares = miscompares + 1;
                $display("FAIL pop unexpected beat: got %h want none", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    miscompares = miscompares + 1;
                    $display("FAIL pop order: got %h want %h", out_data, e);
                end
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        out_ready   = 1'b0;
        #1;
        rst = 1'b1;
        expect_stat("reset", 1'b1, 1'b0, 1'b1, INIT_V, 1'b1);
        step();
        step();
        rst = 1'b0;

        // Single transfer into an empty buffer
        push_beat(8'hA5);
        step();
        in_valid = 1'b0;
        expect_stat("single", 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        expect_stat("single_drain", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();

        // Skid fill then drain
        push_beat(8'h11);
        step();
        push_beat(8'h22);
        step();
        in_valid = 1'b0;
        expect_stat("skid_full", 1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
        out_ready = 1'b1;
        step();
        expect_stat("skid_pop1", 1'b1, 1'b1, 1'b1, 8'h22, 1'b0);
        step();
        out_ready = 1'b0;
        expect_stat("skid_empty", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_beat(i[7:0]);
            expect_stat("stream", 1'b1, (i != 0), (i != 0), i[7:0] - 8'd1, 1'b0);
            step();
        end
        in_valid = 1'b0;
        expect_stat("stream_last", 1'b1, 1'b1, 1'b1, 8'd15, 1'b0);
        step();
        out_ready = 1'b0;
        expect_stat("stream_done", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();

        // Push and pop on the same edge while holding one entry
        push_beat(8'h33);
        step();
        in_valid = 1'b0;
        expect_stat("simul_hold", 1'b1, 1'b1, 1'b1, 8'h33, 1'b0);
        step();
        push_beat(8'h44);
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        expect_stat("simul_one", 1'b1, 1'b1, 1'b1, 8'h44, 1'b0);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        expect_stat("simul_done", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();

        // Flush from FULL with a competing input
        push_beat(8'h55);
        step();
        push_beat(8'h66);
        step();
        in_valid = 1'b1;
        in_data  = 8'h99;
        flush    = 1'b1;
        expect_stat("flush_full", 1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        expect_stat("flush_empty", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        expect_stat("flush_nocapture", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();

        // Asynchronous reset while FULL
        push_beat(8'h12);
        step();
        push_beat(8'h34);
        step();
        in_valid = 1'b0;
        expect_stat("rst_full", 1'b0, 1'b1, 1'b1, 8'h12, 1'b0);
        step();
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        expect_stat("rst_mid", 1'b1, 1'b0, 1'b1, INIT_V, 1'b1);
        step();
        rst = 1'b0;
        step();
        push_beat(8'h77);
        step();
        in_valid = 1'b0;
        expect_stat("rst_push", 1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        expect_stat("rst_drain", 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        step();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pipe_skid_buf
